// File: rtl/pulse_gen_pkg.sv
// Shared state/mode encodings and default constants for the programmable pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StTail = 2'd2
    } ch_state_e;

    typedef enum logic {
        ModePeriodic = 1'b0,
        ModeOneshot  = 1'b1
    } ch_mode_e;

    localparam int unsigned DefNumCh  = 4;
    localparam int unsigned DefCntW   = 27;
    localparam int unsigned DefWidW   = 8;
    localparam int unsigned DefPeriod = 100_000_000;
    localparam int unsigned DefWidth  = 1;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: period counter, width counter and IDLE/RUN/TAIL sequencing.
module pulse_channel
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W          = DefCntW,
    parameter int unsigned WID_W          = DefWidW,
    parameter int unsigned DEFAULT_PERIOD = DefPeriod
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [WID_W-1:0] cfg_width,
    input  logic             cfg_oneshot,
    output logic             pulse,
    output logic             busy
);

    ch_state_e        state_q;
    ch_mode_e         mode_q;
    logic [CNT_W-1:0] count_q, period_q;
    logic [WID_W-1:0] wcnt_q, width_q;
    logic             pulse_q, busy_q;

    logic             terminal;
    logic             pulse_ends;
    logic [WID_W-1:0] wload;
    logic [WID_W-1:0] wcnt_dec;
    logic             pulse_dec;

    always_comb begin
        terminal   = (count_q == period_q - CNT_W'(1));
        pulse_ends = pulse_q && (wcnt_q == '0);
        // A zero width is stretched to one cycle.
        wload      = (width_q == '0) ? '0 : width_q - WID_W'(1);
        wcnt_dec   = wcnt_q;
        pulse_dec  = pulse_q;
        if (pulse_q) begin
            if (wcnt_q != '0) begin
                wcnt_dec = wcnt_q - WID_W'(1);
            end else begin
                pulse_dec = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            mode_q   <= ModePeriodic;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            width_q  <= WID_W'(DefWidth);
            count_q  <= '0;
            wcnt_q   <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (cfg_load) begin
            period_q <= cfg_period;
            width_q  <= cfg_width;
            mode_q   <= cfg_oneshot ? ModeOneshot : ModePeriodic;
            count_q  <= '0;
            wcnt_q   <= '0;
            pulse_q  <= 1'b0;
            state_q  <= (enable && !cfg_oneshot) ? StRun : StIdle;
            busy_q   <= enable && !cfg_oneshot;
        end else if (!enable || start) begin
            // Disable clears everything; start (re)arms from a zero count in either mode.
            count_q <= '0;
            wcnt_q  <= '0;
            pulse_q <= 1'b0;
            state_q <= enable ? StRun : StIdle;
            busy_q  <= enable;
        end else if (state_q == StTail) begin
            wcnt_q  <= wcnt_dec;
            pulse_q <= pulse_dec;
            if (pulse_ends) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end
        end else if (state_q == StRun || mode_q == ModePeriodic) begin
            // An enabled periodic channel counts from its very first enabled edge.
            busy_q <= 1'b1;
            if (terminal) begin
                pulse_q <= 1'b1;
                wcnt_q  <= wload;
                if (mode_q == ModeOneshot) begin
                    state_q <= StTail;
                end else begin
                    state_q <= StRun;
                    count_q <= '0;
                end
            end else begin
                state_q <= StRun;
                count_q <= count_q + CNT_W'(1);
                wcnt_q  <= wcnt_dec;
                pulse_q <= pulse_dec;
            end
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;

endmodule

// File: rtl/programmable_pulse_generator.sv
// Multi-channel programmable pulse generator: config decode/validation plus NUM_CH channels.
module programmable_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH         = DefNumCh,
    parameter int unsigned CNT_W          = DefCntW,
    parameter int unsigned WID_W          = DefWidW,
    parameter int unsigned DEFAULT_PERIOD = DefPeriod
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_CH-1:0]                                 enable,
    input  logic [NUM_CH-1:0]                                 start,
    input  logic                                              cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]                                  cfg_period,
    input  logic [WID_W-1:0]                                  cfg_width,
    input  logic                                              cfg_oneshot,
    output logic [NUM_CH-1:0]                                 pulse,
    output logic [NUM_CH-1:0]                                 busy,
    output logic                                              cfg_err
);

    logic              cfg_ok;
    logic [NUM_CH-1:0] cfg_load;
    logic              cfg_err_q;

    // A zero period or a select beyond the last channel is rejected outright.
    always_comb begin
        cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH) && (cfg_period != '0);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_load[i] = cfg_ok && (32'(cfg_ch) == i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !cfg_ok;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_channel #(
            .CNT_W          (CNT_W),
            .WID_W          (WID_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .enable      (enable[g]),
            .start       (start[g]),
            .cfg_load    (cfg_load[g]),
            .cfg_period  (cfg_period),
            .cfg_width   (cfg_width),
            .cfg_oneshot (cfg_oneshot),
            .pulse       (pulse[g]),
            .busy        (busy[g])
        );
    end

endmodule

// File: tb/tb_programmable_pulse_generator.sv
// Scoreboard bench: per-cycle expectations are queued with the stimulus and checked after the edge.
module tb_programmable_pulse_generator;

    // Three channels so the 2-bit select has an unused code to reject.
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WID_W  = 4;
    localparam int unsigned DEF_P  = 200;

    typedef struct packed {
        logic [2:0] pulse;
        logic [2:0] busy;
        logic       err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       enable = '0;
    logic [2:0]       start = '0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [WID_W-1:0] cfg_width = '0;
    logic             cfg_oneshot = 1'b0;
    logic [2:0]       pulse;
    logic [2:0]       busy;
    logic             cfg_err;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    programmable_pulse_generator #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .WID_W          (WID_W),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_width   (cfg_width),
        .cfg_oneshot (cfg_oneshot),
        .pulse       (pulse),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pulse"}, 32'(pulse), 32'(e.pulse));
            check({tag, "_busy"}, 32'(busy), 32'(e.busy));
            check({tag, "_err"}, 32'(cfg_err), 32'(e.err));
        end
    endtask

    // Drive is already set up; one clock edge, then compare away from the edge.
    task automatic step(input string tag, input logic [2:0] ep, input logic [2:0] eb,
                        input logic ee);
        exp_q.push_back(exp_t'{pulse: ep, busy: eb, err: ee});
        @(posedge clk);
        #1;
        pop_compare(tag);
        cfg_we = 1'b0;
        start  = '0;
    endtask

    task automatic check_now(input string tag, input logic [2:0] ep, input logic [2:0] eb,
                             input logic ee);
        exp_q.push_back(exp_t'{pulse: ep, busy: eb, err: ee});
        #1;
        pop_compare(tag);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input int p, input int w, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = ch;
        cfg_period  = CNT_W'(p);
        cfg_width   = WID_W'(w);
        cfg_oneshot = os;
    endtask

    // Periodic reference: k = enabled edges since the channel (re)started.
    function automatic logic per_pulse(input int k, input int p, input int w);
        int wm;
        wm = (w == 0) ? 1 : w;
        if (k < p) return 1'b0;
        return (k % p) < wm;
    endfunction

    task automatic run_per(input string tag, input int k0, input int n, input int p,
                           input int w, input logic [2:0] other_busy);
        for (int k = k0; k < k0 + n; k++) begin
            step(tag, {2'b00, per_pulse(k, p, w)}, other_busy | 3'b001, 1'b0);
        end
    endtask

    initial begin
        // Reset dominates even with every channel enabled.
        enable = 3'b111;
        check_now("rst_async", 3'b000, 3'b000, 1'b0);
        step("rst_hold", 3'b000, 3'b000, 1'b0);
        enable = '0;
        reset  = 1'b1;

        // Periodic P=5 W=1; channel 1 runs at the default period alongside.
        cfg_write(2'd0, 5, 1, 1'b0);
        step("cfg5", 3'b000, 3'b000, 1'b0);
        enable = 3'b011;
        run_per("per5", 1, 16, 5, 1, 3'b010);

        // Rejected writes leave the cadence alone.
        cfg_write(2'd0, 0, 2, 1'b1);
        step("rej_p0", {2'b00, per_pulse(17, 5, 1)}, 3'b011, 1'b1);
        cfg_write(2'd3, 7, 2, 1'b0);
        step("rej_ch3", {2'b00, per_pulse(18, 5, 1)}, 3'b011, 1'b1);
        run_per("per5_after", 19, 8, 5, 1, 3'b010);

        // Width 3 in period 6, then W>=P.
        enable = 3'b001;
        cfg_write(2'd0, 6, 3, 1'b0);
        step("wr6", 3'b000, 3'b001, 1'b0);
        run_per("w3", 1, 18, 6, 3, 3'b000);
        cfg_write(2'd0, 4, 4, 1'b0);
        step("wr4", 3'b000, 3'b001, 1'b0);
        run_per("wgep", 1, 10, 4, 4, 3'b000);

        // W=0 acts as W=1; P=1 holds the output high.
        cfg_write(2'd0, 3, 0, 1'b0);
        step("wr3w0", 3'b000, 3'b001, 1'b0);
        run_per("w0", 1, 7, 3, 0, 3'b000);
        cfg_write(2'd0, 1, 0, 1'b0);
        step("wr1", 3'b000, 3'b001, 1'b0);
        run_per("p1", 1, 4, 1, 0, 3'b000);

        // Enable drop mid-pulse, restart, then async reset mid-pulse.
        cfg_write(2'd0, 5, 3, 1'b0);
        step("wr5w3", 3'b000, 3'b001, 1'b0);
        run_per("mid", 1, 6, 5, 3, 3'b000);
        enable = '0;
        step("en_off", 3'b000, 3'b000, 1'b0);
        step("en_off2", 3'b000, 3'b000, 1'b0);
        enable = 3'b001;
        run_per("restart", 1, 7, 5, 3, 3'b000);
        reset = 1'b0;
        check_now("rst_mid", 3'b000, 3'b000, 1'b0);
        enable = '0;
        step("rst_mid_hold", 3'b000, 3'b000, 1'b0);
        reset = 1'b1;
        step("rst_rel", 3'b000, 3'b000, 1'b0);
        cfg_write(2'd0, 5, 3, 1'b0);
        step("wr_after_rst", 3'b000, 3'b000, 1'b0);
        enable = 3'b001;
        run_per("after_rst", 1, 7, 5, 3, 3'b000);

        // One-shot P=4 W=2: idle until start, one pulse, then idle.
        cfg_write(2'd0, 4, 2, 1'b1);
        step("os_wr", 3'b000, 3'b000, 1'b0);
        for (int j = 0; j < 3; j++) step("os_idle", 3'b000, 3'b000, 1'b0);
        start = 3'b001;
        step("os_start", 3'b000, 3'b001, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            step("os_run", {2'b00, (j == 4 || j == 5)}, {2'b00, (j <= 5)}, 1'b0);
        end

        // Retrigger two edges after the first start.
        start = 3'b001;
        step("rt_start", 3'b000, 3'b001, 1'b0);
        step("rt_1", 3'b000, 3'b001, 1'b0);
        start = 3'b001;
        step("rt_2", 3'b000, 3'b001, 1'b0);
        for (int j = 3; j <= 12; j++) begin
            step("rt_run", {2'b00, (j == 6 || j == 7)}, {2'b00, (j <= 7)}, 1'b0);
        end

        // Start is ignored while disabled.
        enable = '0;
        start  = 3'b001;
        step("os_dis_start", 3'b000, 3'b000, 1'b0);
        enable = 3'b001;
        for (int j = 0; j < 6; j++) step("os_dis_after", 3'b000, 3'b000, 1'b0);

        // Write and start together: the write wins and the channel stays idle.
        cfg_write(2'd0, 4, 2, 1'b1);
        start = 3'b001;
        step("wr_start", 3'b000, 3'b000, 1'b0);
        for (int j = 0; j < 6; j++) step("wr_start_after", 3'b000, 3'b000, 1'b0);

        // Reset restores the default period and periodic mode on every channel.
        reset  = 1'b0;
        check_now("rst2", 3'b000, 3'b000, 1'b0);
        enable = 3'b111;
        step("rst2_hold", 3'b000, 3'b000, 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= int'(DEF_P) + 1; k++) begin
            step("def_period", (k == int'(DEF_P)) ? 3'b111 : 3'b000, 3'b111, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
